grey_ptr_rx: RTL



---
 rtl/grey_ptr_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/grey_ptr_rx.sv
// Receive side of a Gray-coded pointer link: synchronise, decode, accumulate forward distance.
// Optional saturating multi-bit error counter on port err_cnt, enabled by GREY_PTR_RX_ERR_CNT_EN.
module grey_ptr_rx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
`ifdef GREY_PTR_RX_ERR_CNT_EN
    ,
    parameter int ERR_CNT_W   = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] grey_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             delta_valid,
    output logic [WIDTH-1:0] delta,
    input  logic             delta_ready,
    output logic             err_multi_bit,
    output logic             err_overflow
`ifdef GREY_PTR_RX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {S_FILL, S_BASE, S_RUN} state_t;

    function automatic logic [WIDTH-1:0] grey2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
        int unsigned n = 0;
        for (int i = 0; i < WIDTH; i++) n += 32'(v[i]);
        return n;
    endfunction

    state_t                             state_q, state_d;
    logic   [FILL_W-1:0]                fill_cnt_q, fill_cnt_d;
    logic   [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic   [WIDTH-1:0]                 g_prev_q, g_prev_d;
    logic   [WIDTH-1:0]                 bin_q, bin_d;
    logic   [WIDTH-1:0]                 acc_q, acc_d;
    logic                               err_mb_q, err_mb_d;
    logic                               ovf_q, ovf_d;

    logic             fill_active, base_active, run_active;
    logic [WIDTH-1:0] g_sync, bin_sync, bin_prev, inc;
    logic [WIDTH:0]   sum;
    logic             fire;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst)         state_q <= S_FILL;
        else if (clk_en) state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (fill_cnt_q == FILL_W'(SYNC_STAGES - 1)) state_d = S_BASE;
            S_BASE:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_FILL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        fill_active = 1'b0;
        base_active = 1'b0;
        run_active  = 1'b0;
        case (state_q)
            S_FILL:  fill_active = 1'b1;
            S_BASE:  base_active = 1'b1;
            S_RUN:   run_active  = 1'b1;
            default: fill_active = 1'b1;
        endcase
    end

    // ---------------- Datapath ----------------
    assign g_sync      = sync_q[SYNC_STAGES-1];
    assign bin_sync    = grey2bin(g_sync);
    assign bin_prev    = grey2bin(g_prev_q);
    assign inc         = run_active ? (bin_sync - bin_prev) : '0;
    assign sum         = {1'b0, acc_q} + {1'b0, inc};
    assign delta_valid = (acc_q != '0);
    assign fire        = clk_en & delta_valid & delta_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], grey_in};
        fill_cnt_d = fill_active ? fill_cnt_q + FILL_W'(1) : '0;
        g_prev_d   = g_prev_q;
        bin_d      = bin_q;
        err_mb_d   = 1'b0;
        ovf_d      = ovf_q;
        acc_d      = acc_q;

        if (base_active || run_active) begin
            g_prev_d = g_sync;
            bin_d    = bin_sync;
        end
        if (run_active) err_mb_d = (popcount(g_sync ^ g_prev_q) > 1);

        // Acceptance reloads with this cycle's increment so nothing arriving now is dropped.
        if (fire) begin
            acc_d = inc;
        end else if (sum[WIDTH]) begin
            acc_d = '1;
            ovf_d = 1'b1;
        end else begin
            acc_d = sum[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the synchroniser
    // flops are reset too so the FILL window always starts from a known pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt_q <= '0;
            sync_q     <= '0;
            g_prev_q   <= '0;
            bin_q      <= '0;
            acc_q      <= '0;
            err_mb_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (clk_en) begin
            fill_cnt_q <= fill_cnt_d;
            sync_q     <= sync_d;
            g_prev_q   <= g_prev_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            err_mb_q   <= err_mb_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bin_out       = bin_q;
    assign delta         = acc_q;
    assign err_multi_bit = err_mb_q;
    assign err_overflow  = ovf_q;

`ifdef GREY_PTR_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_mb_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)         err_cnt_q <= '0;
        else if (clk_en) err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
